// File: rtl/ac97_frame_tx.sv
// ac97_frame_tx: builds each 256-bit AC97 output frame (tag + slots) and shifts it out MSB first.
// Optional surround slots 6..9 are enabled with `define AC97_TX_SURR_EN.
`default_nettype none

module ac97_frame_tx #(
   parameter int VALID_BITS = 56
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bit_en,
   input  logic        tx_en,
   input  logic        crac_valid,
   input  logic        crac_wr,
   input  logic [19:0] out_slt1,
   input  logic [19:0] out_slt2,
   input  logic [19:0] out_slt3,
   input  logic [19:0] out_slt4,
   input  logic        slt3_vld,
   input  logic        slt4_vld,
`ifdef AC97_TX_SURR_EN
   input  logic [19:0] out_slt6,
   input  logic [19:0] out_slt7,
   input  logic [19:0] out_slt8,
   input  logic [19:0] out_slt9,
   input  logic        slt6_vld,
   input  logic        slt7_vld,
   input  logic        slt8_vld,
   input  logic        slt9_vld,
`endif
   output logic        out_le,
   output logic        valid,
   output logic        sync,
   output logic        sdata_out,
   output logic        busy
);

   localparam int         FRAME_BITS = 256;
   localparam logic [7:0] LAST_BIT   = 8'(FRAME_BITS - 1);
   localparam logic [7:0] SYNC_BITS  = 8'd16;
   localparam logic [7:0] VALID_END  = 8'(VALID_BITS);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_TX   = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              idx_q, idx_d;
   logic [FRAME_BITS-1:0]   frame_q, frame_d;
   logic                    le_q, le_d;

   logic [14:0]             tag_lo;
   logic [15:0]             tag;
   logic [FRAME_BITS-1:0]   frame_new;
   logic                    load;

   always_comb begin
      tag_lo     = '0;
      tag_lo[14] = crac_valid;
      tag_lo[13] = crac_valid & crac_wr;
      tag_lo[12] = slt3_vld;
      tag_lo[11] = slt4_vld;
`ifdef AC97_TX_SURR_EN
      tag_lo[9]  = slt6_vld;
      tag_lo[8]  = slt7_vld;
      tag_lo[7]  = slt8_vld;
      tag_lo[6]  = slt9_vld;
`endif
   end

   // Frame-valid bit summarises every slot-valid flag in the tag.
   assign tag = {|tag_lo[14:3], tag_lo};

`ifdef AC97_TX_SURR_EN
   assign frame_new = {tag, out_slt1, out_slt2, out_slt3, out_slt4, 20'd0,
                       out_slt6, out_slt7, out_slt8, out_slt9, 60'd0};
`else
   assign frame_new = {tag, out_slt1, out_slt2, out_slt3, out_slt4, 160'd0};
`endif

   // A new frame starts from IDLE or directly after the last bit of the previous one.
   assign load = bit_en & tx_en & ((state_q == S_IDLE) | (idx_q == LAST_BIT));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      le_d    = 1'b0;
      if (load) begin
         state_d = S_TX;
         idx_d   = 8'd0;
         frame_d = frame_new;
         le_d    = 1'b1;
      end else if (bit_en && state_q == S_TX) begin
         if (idx_q == LAST_BIT) begin
            state_d = S_IDLE;
            idx_d   = 8'd0;
            frame_d = '0;
         end else begin
            idx_d   = idx_q + 8'd1;
            frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= 8'd0;
         frame_q <= '0;
         le_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         le_q    <= le_d;
      end
   end

   // frame_q is cleared in IDLE, so the MSB is already 0 there.
   assign sdata_out = frame_q[FRAME_BITS-1];
   assign busy      = (state_q == S_TX);
   assign sync      = busy && (idx_q < SYNC_BITS);
   assign valid     = busy && (idx_q < VALID_END);
   assign out_le    = le_q;

endmodule

`default_nettype wire

// File: tb/tb_ac97_frame_tx.sv
// tb_ac97_frame_tx: scoreboard bench for ac97_frame_tx (default build, no surround slots).
`default_nettype none

module tb_ac97_frame_tx;

   logic        clk, rst, bit_en, tx_en, crac_valid, crac_wr;
   logic [19:0] out_slt1, out_slt2, out_slt3, out_slt4;
   logic        slt3_vld, slt4_vld;
   logic        out_le, valid, sync, sdata_out, busy;

   ac97_frame_tx #(.VALID_BITS(56)) dut (
      .clk(clk), .rst(rst), .bit_en(bit_en), .tx_en(tx_en),
      .crac_valid(crac_valid), .crac_wr(crac_wr),
      .out_slt1(out_slt1), .out_slt2(out_slt2), .out_slt3(out_slt3), .out_slt4(out_slt4),
      .slt3_vld(slt3_vld), .slt4_vld(slt4_vld),
      .out_le(out_le), .valid(valid), .sync(sync), .sdata_out(sdata_out), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic sd;
      logic sy;
      logic va;
   } exp_t;

   exp_t         sbq[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   logic         mbusy    = 1'b0;
   int           mcnt     = 0;
   logic [255:0] obs      = '0;
   int           le_seen  = 0;
   int           valid_cnt = 0;
   int           be_cnt   = 0;
   int           le_be    = 0;
   int           le_gap   = 0;

   function automatic logic [255:0] model_frame();
      logic [15:0] t;
      t     = '0;
      t[14] = crac_valid;
      t[13] = crac_valid & crac_wr;
      t[12] = slt3_vld;
      t[11] = slt4_vld;
      t[15] = |t[14:11];
      return {t, out_slt1, out_slt2, out_slt3, out_slt4, 160'd0};
   endfunction

   // Scoreboard: push a whole frame when a load is due, pop one bit per bit_en.
   always @(posedge clk) begin : mon
      logic         be, exp_le;
      exp_t         cur, e;
      logic [255:0] f;
      if (rst) begin
         be     = bit_en;
         exp_le = 1'b0;
         cur    = '0;
         if (be) begin
            be_cnt++;
            if (sbq.size() == 0) begin
               if (tx_en) begin
                  f = model_frame();
                  for (int i = 0; i < 256; i++) begin
                     e.sd = f[255-i];
                     e.sy = (i < 16);
                     e.va = (i < 56);
                     sbq.push_back(e);
                  end
                  mbusy     = 1'b1;
                  exp_le    = 1'b1;
                  mcnt      = 0;
                  valid_cnt = 0;
                  le_gap    = be_cnt - le_be;
                  le_be     = be_cnt;
               end else begin
                  mbusy = 1'b0;
               end
            end
            if (mbusy) cur = sbq.pop_front();
         end
         #1;
         if (out_le === 1'b1) le_seen++;
         n_checks++;
         if (out_le !== exp_le) begin
            n_fail++;
            $display("FAIL out_le @%0t: got %b expected %b", $time, out_le, exp_le);
         end
         n_checks++;
         if (busy !== mbusy) begin
            n_fail++;
            $display("FAIL busy @%0t: got %b expected %b", $time, busy, mbusy);
         end
         if (be) begin
            n_checks++;
            if ({sdata_out, sync, valid} !== {cur.sd, cur.sy, cur.va}) begin
               n_fail++;
               $display("FAIL serial bit %0d @%0t: got sd/sync/valid=%b%b%b expected %b%b%b",
                        mcnt, $time, sdata_out, sync, valid, cur.sd, cur.sy, cur.va);
            end
            if (mbusy) begin
               obs[255-mcnt] = sdata_out;
               mcnt++;
               if (valid === 1'b1) valid_cnt++;
            end
         end
      end
   end

   task automatic bits(input int n);
      repeat (n) begin
         @(negedge clk) bit_en = 1'b1;
         @(negedge clk) bit_en = 1'b0;
      end
   endtask

   task automatic set_in(input logic cv, input logic wr, input logic [19:0] s1, input logic [19:0] s2,
                         input logic [19:0] s3, input logic [19:0] s4, input logic v3, input logic v4);
      crac_valid = cv; crac_wr = wr;
      out_slt1 = s1; out_slt2 = s2; out_slt3 = s3; out_slt4 = s4;
      slt3_vld = v3; slt4_vld = v4;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tx_en = 1'b1;
      set_in(1, 1, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 1, 1);
      @(negedge clk) bit_en = 1'b1;
      @(negedge clk) bit_en = 1'b0;
      n_checks++;
      if ({out_le, valid, sync, sdata_out, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset outputs: got %b expected 00000", {out_le, valid, sync, sdata_out, busy});
      end
      tx_en = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) rst = 1'b1;
      bits(3);
      n_checks++;
      if ({out_le, valid, sync, sdata_out, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL idle tx_en=0 outputs: got %b expected 00000", {out_le, valid, sync, sdata_out, busy});
      end
   endtask

   task automatic test_empty_frame();
      int l0;
      l0 = le_seen;
      tx_en = 1'b1;
      bits(1);
      tx_en = 1'b0;
      bits(255);
      n_checks++;
      if (obs !== 256'd0) begin n_fail++; $display("FAIL empty frame: got %h expected 0", obs); end
      n_checks++;
      if (le_seen - l0 != 1) begin n_fail++; $display("FAIL empty le count: got %0d expected 1", le_seen - l0); end
      n_checks++;
      if (valid_cnt != 56) begin n_fail++; $display("FAIL empty valid len: got %0d expected 56", valid_cnt); end
      bits(1);
   endtask

   task automatic test_write();
      set_in(1, 1, 20'h02000, 20'hABCD0, 0, 0, 0, 0);
      tx_en = 1'b1;
      bits(1);
      tx_en = 1'b0;
      bits(255);
      n_checks++;
      if (obs[255:240] !== 16'hE000) begin n_fail++; $display("FAIL write tag: got %h expected e000", obs[255:240]); end
      n_checks++;
      if (obs[239:220] !== 20'h02000) begin n_fail++; $display("FAIL write slot1: got %h expected 02000", obs[239:220]); end
      n_checks++;
      if (obs[219:200] !== 20'hABCD0) begin n_fail++; $display("FAIL write slot2: got %h expected abcd0", obs[219:200]); end
      n_checks++;
      if (valid_cnt != 56) begin n_fail++; $display("FAIL write valid len: got %0d expected 56", valid_cnt); end
      bits(1);
   endtask

   task automatic test_read();
      set_in(1, 0, 20'h8A000, 20'h5A5A5, 0, 0, 0, 0);
      tx_en = 1'b1;
      bits(1);
      tx_en = 1'b0;
      bits(255);
      n_checks++;
      if (obs[255:240] !== 16'hC000) begin n_fail++; $display("FAIL read tag: got %h expected c000", obs[255:240]); end
      n_checks++;
      if (obs[219:200] !== 20'h5A5A5) begin n_fail++; $display("FAIL read slot2: got %h expected 5a5a5", obs[219:200]); end
      bits(1);
   endtask

   task automatic test_pcm_capture();
      set_in(0, 0, 0, 0, 20'h12345, 20'h00000, 1, 0);
      tx_en = 1'b1;
      bits(11);
      out_slt3 = 20'hFFFFF;
      slt4_vld = 1'b1;
      bits(245);
      n_checks++;
      if (obs[255:240] !== 16'h9000) begin n_fail++; $display("FAIL pcm tag: got %h expected 9000", obs[255:240]); end
      n_checks++;
      if (obs[199:180] !== 20'h12345) begin n_fail++; $display("FAIL pcm slot3: got %h expected 12345", obs[199:180]); end
      bits(1);
      tx_en = 1'b0;
      bits(255);
      n_checks++;
      if (obs[255:240] !== 16'h9800) begin n_fail++; $display("FAIL pcm next tag: got %h expected 9800", obs[255:240]); end
      n_checks++;
      if (obs[199:180] !== 20'hFFFFF) begin n_fail++; $display("FAIL pcm next slot3: got %h expected fffff", obs[199:180]); end
      bits(1);
   endtask

   task automatic test_back_to_back();
      int l0;
      set_in(1, 1, 20'h13579, 20'h2468A, 20'h0F0F0, 20'hF0F0F, 1, 1);
      l0 = le_seen;
      tx_en = 1'b1;
      bits(513);
      tx_en = 1'b0;
      bits(255);
      n_checks++;
      if (le_seen - l0 != 3) begin n_fail++; $display("FAIL b2b le count: got %0d expected 3", le_seen - l0); end
      n_checks++;
      if (le_gap != 256) begin n_fail++; $display("FAIL b2b le spacing: got %0d expected 256", le_gap); end
      n_checks++;
      if (obs[255:240] !== 16'hF800) begin n_fail++; $display("FAIL b2b tag: got %h expected f800", obs[255:240]); end
      bits(1);
   endtask

   task automatic test_tx_drop();
      int l0;
      tx_en = 1'b1;
      bits(100);
      tx_en = 1'b0;
      bits(156);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL drop busy at bit 255: got %b expected 1", busy); end
      bits(1);
      l0 = le_seen;
      bits(5);
      n_checks++;
      if (busy !== 1'b0 || le_seen != l0) begin
         n_fail++;
         $display("FAIL drop idle: got busy=%b le=%0d expected busy=0 le=0", busy, le_seen - l0);
      end
   endtask

   task automatic test_abort();
      int pts[2];
      pts[0] = 20;
      pts[1] = 100;
      set_in(0, 0, 20'hFFFFF, 20'h00000, 0, 0, 0, 0);
      foreach (pts[k]) begin
         tx_en = 1'b1;
         bits(1);
         tx_en = 1'b0;
         bits(pts[k]);
         @(negedge clk);
         #2 rst = 1'b0;
         #1;
         n_checks++;
         if ({out_le, valid, sync, sdata_out, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort at bit %0d: got %b expected 00000", pts[k], {out_le, valid, sync, sdata_out, busy});
         end
         sbq.delete();
         mbusy = 1'b0;
         @(negedge clk) rst = 1'b1;
      end
      set_in(1, 0, 20'hC3C3C, 20'h11111, 0, 0, 0, 0);
      tx_en = 1'b1;
      bits(1);
      tx_en = 1'b0;
      bits(255);
      n_checks++;
      if (obs[255:220] !== {16'hC000, 20'hC3C3C}) begin
         n_fail++;
         $display("FAIL post-abort frame: got %h expected c000c3c3c", obs[255:220]);
      end
      bits(1);
   endtask

   initial begin
      rst = 1'b0; bit_en = 1'b0; tx_en = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_empty_frame();
      test_write();
      test_read();
      test_pcm_capture();
      test_back_to_back();
      test_tx_drop();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
